// File: rtl/tile_sched_pkg.sv
// Shared types and default sizes for the tile redraw scheduler and its helpers.
// The state enum and mask type are also used by the game-logic side of the board.
package tile_sched_pkg;

    localparam int DEF_NUM_TILES = 16;
    localparam int DEF_ADDR_W    = 4;
    localparam int DEF_ID_W      = 4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_CAPTURE = 3'd2,
        S_PLOT    = 3'd3,
        S_WAIT    = 3'd4
    } state_e;

    typedef logic [DEF_NUM_TILES-1:0] mask_t;

endpackage

// File: rtl/tile_redraw_scheduler_rr_pick.sv
// Combinational round-robin picker: first set mask bit strictly after `last`,
// wrapping, with `last` itself considered at the very end.
module rr_pick
    import tile_sched_pkg::*;
#(
    parameter int NUM_TILES = DEF_NUM_TILES,
    parameter int ADDR_W    = DEF_ADDR_W
) (
    input  logic [NUM_TILES-1:0] mask,
    input  logic [ADDR_W-1:0]    last,
    output logic [ADDR_W-1:0]    sel,
    output logic                 any
);

    logic [ADDR_W-1:0] idx;

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; a path that skips an assignment infers a latch.
    always_comb begin
        sel = '0;
        any = 1'b0;
        idx = '0;
        // Scan from the farthest offset inward so the nearest candidate is written last and wins.
        for (int i = NUM_TILES; i >= 1; i--) begin
            idx = ADDR_W'((int'(last) + i) % NUM_TILES);
            if (mask[idx]) begin
                sel = idx;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tile_redraw_scheduler.sv
// Incremental board redraw: keeps a dirty mask, picks tiles round-robin, reads
// each tile ID from board RAM and hands it to the display engine one at a time.
module tile_redraw_scheduler
    import tile_sched_pkg::*;
#(
    parameter int NUM_TILES    = DEF_NUM_TILES,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int ID_W         = DEF_ID_W,
    parameter int DONE_TIMEOUT = 4095
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mark_a_valid,
    input  logic [ADDR_W-1:0] mark_a_addr,
    input  logic              mark_b_valid,
    input  logic [ADDR_W-1:0] mark_b_addr,
    input  logic              full_redraw,
    input  logic              hold,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [ID_W-1:0]   ram_rd_data,
    output logic              plot,
    output logic [ADDR_W-1:0] plot_addr,
    output logic [ID_W-1:0]   plot_id,
    input  logic              done,
    output logic              idle,
    output logic              err_timeout
);

    localparam int                TO_W     = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
    localparam logic [TO_W-1:0]   TO_LAST  = TO_W'((DONE_TIMEOUT > 0) ? DONE_TIMEOUT - 1 : 0);
    localparam logic [ADDR_W-1:0] LAST_RST = ADDR_W'(NUM_TILES - 1);

    state_e                 state_q, state_d;
    logic [NUM_TILES-1:0]   mask_q, mask_d;
    logic [ADDR_W-1:0]      last_q, last_d;
    logic [ADDR_W-1:0]      sel_q, sel_d;
    logic [ADDR_W-1:0]      ram_addr_q, ram_addr_d;
    logic [ADDR_W-1:0]      plot_addr_q, plot_addr_d;
    logic [ID_W-1:0]        plot_id_q, plot_id_d;
    logic                   plot_q, plot_d;
    logic                   idle_q, idle_d;
    logic                   err_q, err_d;
    logic [TO_W-1:0]        cnt_q, cnt_d;

    logic [ADDR_W-1:0]      pick_sel;
    logic                   pick_any;

    rr_pick #(
        .NUM_TILES (NUM_TILES),
        .ADDR_W    (ADDR_W)
    ) u_pick (
        .mask (mask_q),
        .last (last_q),
        .sel  (pick_sel),
        .any  (pick_any)
    );

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        last_d      = last_q;
        sel_d       = sel_q;
        ram_addr_d  = ram_addr_q;
        plot_addr_d = plot_addr_q;
        plot_id_d   = plot_id_q;
        plot_d      = 1'b0;
        err_d       = err_q;
        cnt_d       = '0;
        idle_d      = (state_q == S_IDLE) && (mask_q == '0);

        case (state_q)
            S_IDLE: begin
                if (pick_any && !hold) begin
                    sel_d      = pick_sel;
                    ram_addr_d = pick_sel;
                    state_d    = S_READ;
                end
            end
            S_READ: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                plot_id_d      = ram_rd_data;
                plot_addr_d    = sel_q;
                mask_d[sel_q]  = 1'b0;
                last_d         = sel_q;
                plot_d         = 1'b1;
                state_d        = S_PLOT;
            end
            S_PLOT: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (done) begin
                    state_d = S_IDLE;
                end else if ((DONE_TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
                    // Abandon the draw but keep the tile dirty so it is retried.
                    err_d         = 1'b1;
                    mask_d[sel_q] = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Sets are applied after the CAPTURE clear so a mark on the in-flight tile survives.
        if (full_redraw) begin
            mask_d = '1;
        end
        if (mark_a_valid) begin
            mask_d[mark_a_addr] = 1'b1;
        end
        if (mark_b_valid) begin
            mask_d[mark_b_addr] = 1'b1;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            mask_q      <= '1;
            last_q      <= LAST_RST;
            sel_q       <= '0;
            ram_addr_q  <= '0;
            plot_addr_q <= '0;
            plot_id_q   <= '0;
            plot_q      <= 1'b0;
            idle_q      <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            last_q      <= last_d;
            sel_q       <= sel_d;
            ram_addr_q  <= ram_addr_d;
            plot_addr_q <= plot_addr_d;
            plot_id_q   <= plot_id_d;
            plot_q      <= plot_d;
            idle_q      <= idle_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign ram_addr    = ram_addr_q;
    assign plot        = plot_q;
    assign plot_addr   = plot_addr_q;
    assign plot_id     = plot_id_q;
    assign idle        = idle_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_tile_redraw_scheduler.sv
// Self-checking bench for tile_redraw_scheduler: a tile-level reference model is
// compared against the DUT outputs every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_tile_redraw_scheduler;
    import tile_sched_pkg::*;

    localparam int NT = 16;
    localparam int TO = 8;

    logic       clock = 1'b0;
    logic       reset;
    logic       mark_a_valid, mark_b_valid;
    logic [3:0] mark_a_addr, mark_b_addr;
    logic       full_redraw, hold;
    logic [3:0] ram_addr;
    logic [3:0] ram_rd_data;
    logic       plot;
    logic [3:0] plot_addr, plot_id;
    logic       done;
    logic       idle, err_timeout;

    tile_redraw_scheduler #(
        .NUM_TILES    (NT),
        .ADDR_W       (4),
        .ID_W         (4),
        .DONE_TIMEOUT (TO)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .mark_a_valid (mark_a_valid),
        .mark_a_addr  (mark_a_addr),
        .mark_b_valid (mark_b_valid),
        .mark_b_addr  (mark_b_addr),
        .full_redraw  (full_redraw),
        .hold         (hold),
        .ram_addr     (ram_addr),
        .ram_rd_data  (ram_rd_data),
        .plot         (plot),
        .plot_addr    (plot_addr),
        .plot_id      (plot_id),
        .done         (done),
        .idle         (idle),
        .err_timeout  (err_timeout)
    );

    always #5 clock = ~clock;

    // Board RAM with one-cycle registered read.
    logic [3:0] ram [NT];
    always @(posedge clock) ram_rd_data <= ram[ram_addr];

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model (tile level) ----------------
    bit [NT-1:0] m_mask;
    int          m_last, m_sel, m_age, m_wait, m_data;
    bit          m_busy;
    bit          model_valid = 1'b0;
    int          e_ram_addr, e_plot_addr, e_plot_id;
    bit          e_plot, e_idle, e_err;

    task automatic model_step();
        if (reset === 1'b1) begin
            m_mask = '1; m_last = NT - 1; m_busy = 1'b0;
            e_ram_addr = 0; e_plot_addr = 0; e_plot_id = 0;
            e_plot = 1'b0; e_idle = 1'b0; e_err = 1'b0;
            model_valid = 1'b1;
            return;
        end
        if (!model_valid) return;
        e_idle = !m_busy && (m_mask == 0);
        e_plot = 1'b0;
        if (!m_busy) begin
            if (m_mask != 0 && !hold) begin
                for (int k = 1; k <= NT; k++) begin
                    if (m_mask[(m_last + k) % NT]) begin
                        m_sel = (m_last + k) % NT;
                        break;
                    end
                end
                m_busy = 1'b1; m_age = 1; e_ram_addr = m_sel;
            end
        end else if (m_age == 1) begin
            m_data = int'(ram[m_sel]); m_age = 2;
        end else if (m_age == 2) begin
            e_plot_id = m_data; e_plot_addr = m_sel;
            m_mask[m_sel] = 1'b0; m_last = m_sel;
            e_plot = 1'b1; m_age = 3;
        end else if (m_age == 3) begin
            m_age = 4; m_wait = 0;
        end else begin
            m_wait++;
            if (done) begin
                m_busy = 1'b0;
            end else if (m_wait == TO) begin
                e_err = 1'b1; m_mask[m_sel] = 1'b1; m_busy = 1'b0;
            end
        end
        if (full_redraw)  m_mask = '1;
        if (mark_a_valid) m_mask[mark_a_addr] = 1'b1;
        if (mark_b_valid) m_mask[mark_b_addr] = 1'b1;
    endtask

    always @(posedge clock) model_step();

    // ---------------- per-cycle compare and plot log ----------------
    typedef struct { int addr; int id; int cyc; } plot_rec_t;
    plot_rec_t plot_log[$];

    task automatic compare_step();
        if (!model_valid) return;
        check("ram_addr",    ram_addr,    e_ram_addr);
        check("plot",        plot,        e_plot);
        check("plot_addr",   plot_addr,   e_plot_addr);
        check("plot_id",     plot_id,     e_plot_id);
        check("idle",        idle,        e_idle);
        check("err_timeout", err_timeout, e_err);
        if (plot === 1'b1) plot_log.push_back('{int'(plot_addr), int'(plot_id), cyc});
    endtask

    always @(negedge clock) compare_step();

    // ---------------- display engine responder ----------------
    int done_mode = 0;  // 0: done 3 cycles after plot, 1: never, 2: random
    int done_cd   = 0;

    task automatic done_step();
        if (plot === 1'b1) begin
            done_cd = 3;
            done = (done_mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
        end else if (done_mode == 2) begin
            done = ($urandom_range(0, 3) == 0);
        end else if (done_cd > 0) begin
            done_cd--;
            done = (done_cd == 0) && (done_mode == 0);
        end else begin
            done = 1'b0;
        end
    endtask

    always @(negedge clock) done_step();

    // ---------------- driver helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic pulse_marks(input bit va, input int aa, input bit vb, input int ab);
        mark_a_valid = va; mark_a_addr = 4'(aa);
        mark_b_valid = vb; mark_b_addr = 4'(ab);
        tick(1);
        mark_a_valid = 1'b0; mark_b_valid = 1'b0;
    endtask

    task automatic wait_plots(input int n, input int budget, input string name);
        int k = 0;
        while (plot_log.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        check(name, (plot_log.size() >= n), 1);
    endtask

    task automatic wait_idle(input int budget, input string name, output int at_cyc);
        int k = 0;
        while (idle !== 1'b1 && k < budget) begin
            tick(1);
            k++;
        end
        at_cyc = cyc;
        check(name, idle, 1'b1);
    endtask

    task automatic check_plot(input string name, input int i, input int a, input int id);
        if (i < plot_log.size()) begin
            check($sformatf("%s_addr", name), plot_log[i].addr, a);
            check($sformatf("%s_id", name),   plot_log[i].id,   id);
        end else begin
            check($sformatf("%s_present", name), plot_log.size(), i + 1);
        end
    endtask

    task automatic check_paint_in_order(input string name);
        check($sformatf("%s_count", name), plot_log.size(), 16);
        for (int i = 0; i < NT; i++) check_plot($sformatf("%s_%0d", name, i), i, i, int'(ram[i]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "bench did not complete");
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        int t_idle, t_err, k;
        reset = 1'b1; hold = 1'b0; full_redraw = 1'b0; done = 1'b0;
        mark_a_valid = 1'b0; mark_a_addr = '0; mark_b_valid = 1'b0; mark_b_addr = '0;
        for (int i = 0; i < NT; i++) ram[i] = 4'(i);
        tick(3);
        check("reset_plot", plot, 1'b0);
        check("reset_err",  err_timeout, 1'b0);
        reset = 1'b0;

        // Full paint after reset: 0..15 in order, 7 cycles apart, idle 5 cycles after last plot.
        wait_plots(16, 300, "paint_wait");
        check_paint_in_order("paint");
        if (plot_log.size() >= 2) check("paint_gap", plot_log[1].cyc - plot_log[0].cyc, 7);
        wait_idle(50, "paint_idle", t_idle);
        if (plot_log.size() >= 16) check("paint_idle_lag", t_idle - plot_log[15].cyc, 5);

        // Swap: tiles 5 and 9 marked together.
        ram[5] = 4'd10; ram[9] = 4'd6;
        plot_log.delete();
        pulse_marks(1'b1, 5, 1'b1, 9);
        wait_plots(2, 60, "swap_wait");
        wait_idle(60, "swap_idle", t_idle);
        check("swap_count", plot_log.size(), 2);
        check_plot("swap0", 0, 5, 10);
        check_plot("swap1", 1, 9, 6);

        // Re-mark the in-flight tile with new RAM contents.
        ram[7] = 4'd3;
        plot_log.delete();
        pulse_marks(1'b1, 7, 1'b1, 7);
        wait_plots(1, 60, "remark_wait1");
        tick(1);
        ram[7] = 4'd12;
        pulse_marks(1'b1, 7, 1'b0, 0);
        wait_plots(2, 60, "remark_wait2");
        wait_idle(60, "remark_idle", t_idle);
        check("remark_count", plot_log.size(), 2);
        check_plot("remark0", 0, 7, 3);
        check_plot("remark1", 1, 7, 12);

        // Hold blocks selection of tiles 0 and 1.
        hold = 1'b1;
        plot_log.delete();
        pulse_marks(1'b1, 0, 1'b1, 1);
        tick(20);
        check("hold_no_plot", plot_log.size(), 0);
        check("hold_not_idle", idle, 1'b0);
        hold = 1'b0;
        wait_plots(2, 60, "hold_release_wait");
        check_plot("hold0", 0, 0, 0);
        check_plot("hold1", 1, 1, 1);
        wait_idle(60, "hold_idle", t_idle);

        // Timeout: done withheld, tile 3 retried.
        done_mode = 1;
        plot_log.delete();
        pulse_marks(1'b1, 3, 1'b0, 0);
        wait_plots(1, 60, "to_wait1");
        check("to_err_before", err_timeout, 1'b0);
        k = 0;
        while (err_timeout !== 1'b1 && k < 40) begin
            tick(1);
            k++;
        end
        t_err = cyc;
        check("to_err_set", err_timeout, 1'b1);
        if (plot_log.size() >= 1) check("to_err_lag", t_err - plot_log[0].cyc, 9);
        wait_plots(2, 60, "to_wait2");
        done_mode = 0;
        check_plot("to_retry", 1, 3, 3);
        if (plot_log.size() >= 2) check("to_retry_gap", plot_log[1].cyc - plot_log[0].cyc, 12);
        wait_idle(60, "to_idle", t_idle);
        tick(10);
        check("to_err_sticky", err_timeout, 1'b1);

        // Reset mid-draw on tile 4, then full repaint from tile 0.
        reset = 1'b1; tick(1); reset = 1'b0;
        plot_log.delete();
        wait_plots(5, 100, "mid_wait");
        check_plot("mid_tile4", 4, 4, int'(ram[4]));
        tick(1);
        reset = 1'b1; tick(1); reset = 1'b0;
        plot_log.delete();
        wait_plots(16, 300, "mid_repaint_wait");
        check_paint_in_order("mid_repaint");
        wait_idle(60, "mid_idle", t_idle);

        // Full redraw while idle.
        plot_log.delete();
        full_redraw = 1'b1; tick(1); full_redraw = 1'b0;
        wait_plots(16, 300, "full_wait");
        check_paint_in_order("full");
        wait_idle(60, "full_idle", t_idle);

        // Randomised traffic checked cycle by cycle against the model.
        done_mode = 2;
        for (int c = 0; c < 2000; c++) begin
            mark_a_valid = ($urandom_range(0, 7) == 0);
            mark_a_addr  = 4'($urandom_range(0, 15));
            mark_b_valid = ($urandom_range(0, 7) == 0);
            mark_b_addr  = ($urandom_range(0, 3) == 0) ? mark_a_addr : 4'($urandom_range(0, 15));
            full_redraw  = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 29) == 0) hold = ~hold;
            if ($urandom_range(0, 3) == 0) ram[$urandom_range(0, 15)] = 4'($urandom_range(0, 15));
            reset = ($urandom_range(0, 499) == 0);
            tick(1);
        end
        mark_a_valid = 1'b0; mark_b_valid = 1'b0; full_redraw = 1'b0;
        hold = 1'b0; reset = 1'b0; done_mode = 0;
        wait_idle(600, "random_drain_idle", t_idle);
        tick(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
